// File: rtl/multicycle_adder.sv
// -----------------------------------------------------------------------------
// multicycle_adder
//   Digit-serial adder/subtractor. An accepted operation adds one DIGIT-bit
//   slice per clock, least significant slice first, rippling the carry
//   between cycles through a register. A result takes N = WIDTH/DIGIT RUN
//   cycles followed by one DONE cycle.
//
// Ports
//   clk    : clock, all state changes on the rising edge
//   rst_n  : synchronous active-low reset
//   start  : request a new operation (only honoured in IDLE)
//   a, b   : operands, captured with start
//   c_in   : carry-in for add mode, captured with start
//   sub    : 0 = a + b + c_in, 1 = a - b (c_in ignored), captured with start
//   busy   : high while the FSM is not IDLE
//   done   : one-cycle pulse marking a valid result
//   sum    : result, held from done until the next accepted start
//   c_out  : carry out of the MSB (subtract: 1 = no borrow)
//   ovf    : two's-complement signed overflow
// -----------------------------------------------------------------------------
module multicycle_adder #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  localparam int N  = WIDTH / DIGIT;
  // Counter must be able to hold N itself so it never wraps within one op.
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);
  // Operands shift down one slice per RUN cycle; with a single slice there is
  // nothing left to shift.
  localparam int SHIFT = (N > 1) ? DIGIT : 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_next_s;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] a_op_r;
  logic [WIDTH-1:0] b_op_r;
  logic             carry_r;
  logic [WIDTH-1:0] sum_r;
  logic             c_out_r;
  logic             ovf_r;
  logic             busy_r;
  logic             done_r;
  logic             busy_next_s;
  logic             done_next_s;
  logic             accept_s;
  logic             last_s;
  logic [DIGIT-1:0] slice_sum_s;
  logic             slice_cout_s;
  logic             slice_cmsb_s;
  logic [WIDTH-1:0] slice_top_s;

  // Adds one slice and returns {carry out, carry into slice MSB, slice sum}.
  // The carry into the MSB is recovered from the MSB sum bit and its inputs.
  function automatic logic [DIGIT+1:0] add_slice(
    input logic [DIGIT-1:0] x,
    input logic [DIGIT-1:0] y,
    input logic             cin
  );
    logic [DIGIT:0] full;
    logic           cmsb;
    full = {1'b0, x} + {1'b0, y} + {{DIGIT{1'b0}}, cin};
    cmsb = x[DIGIT-1] ^ y[DIGIT-1] ^ full[DIGIT-1];
    return {full[DIGIT], cmsb, full[DIGIT-1:0]};
  endfunction

  assign accept_s = (state_r == IDLE) && start;
  assign last_s   = (cnt_r == LAST_CNT);

  // Slice adder on the low slice of the (shifting) operand registers.
  always_comb begin
    {slice_cout_s, slice_cmsb_s, slice_sum_s} =
      add_slice(a_op_r[DIGIT-1:0], b_op_r[DIGIT-1:0], carry_r);
    slice_top_s = WIDTH'(slice_sum_s) << (WIDTH - DIGIT);
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE:    state_next_s = start  ? RUN  : IDLE;
      RUN:     state_next_s = last_s ? DONE : RUN;
      DONE:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // FSM output decode, computed from the next state so the registered
  // busy/done line up with the state they describe.
  always_comb begin
    busy_next_s = 1'b0;
    done_next_s = 1'b0;
    case (state_next_s)
      IDLE:    begin busy_next_s = 1'b0; done_next_s = 1'b0; end
      RUN:     begin busy_next_s = 1'b1; done_next_s = 1'b0; end
      DONE:    begin busy_next_s = 1'b1; done_next_s = 1'b1; end
      default: begin busy_next_s = 1'b0; done_next_s = 1'b0; end
    endcase
  end

  // Registered status outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= busy_next_s;
      done_r <= done_next_s;
    end
  end

  // Datapath: operand capture, per-slice add and result assembly.
  // Subtraction is folded in at capture time as a + ~b + 1.
  // Each slice result enters sum at the top and shifts down, so after N
  // cycles the first (least significant) slice lands in bits DIGIT-1:0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_op_r  <= {WIDTH{1'b0}};
      b_op_r  <= {WIDTH{1'b0}};
      carry_r <= 1'b0;
      cnt_r   <= {CW{1'b0}};
      sum_r   <= {WIDTH{1'b0}};
      c_out_r <= 1'b0;
      ovf_r   <= 1'b0;
    end else if (accept_s) begin
      a_op_r  <= a;
      b_op_r  <= sub ? ~b : b;
      carry_r <= sub ? 1'b1 : c_in;
      cnt_r   <= {CW{1'b0}};
      sum_r   <= {WIDTH{1'b0}};
    end else if (state_r == RUN) begin
      a_op_r  <= a_op_r >> SHIFT;
      b_op_r  <= b_op_r >> SHIFT;
      carry_r <= slice_cout_s;
      cnt_r   <= cnt_r + CW'(1);
      sum_r   <= (sum_r >> SHIFT) | slice_top_s;
      if (last_s) begin
        c_out_r <= slice_cout_s;
        ovf_r   <= slice_cmsb_s ^ slice_cout_s;
      end else begin
        c_out_r <= c_out_r;
        ovf_r   <= ovf_r;
      end
    end else begin
      a_op_r  <= a_op_r;
      b_op_r  <= b_op_r;
      carry_r <= carry_r;
      cnt_r   <= cnt_r;
      sum_r   <= sum_r;
      c_out_r <= c_out_r;
      ovf_r   <= ovf_r;
    end
  end

  assign busy  = busy_r;
  assign done  = done_r;
  assign sum   = sum_r;
  assign c_out = c_out_r;
  assign ovf   = ovf_r;

endmodule

// File: tb/tb_multicycle_adder.sv
// -----------------------------------------------------------------------------
// tb_multicycle_adder
//   Self-checking bench: three instances (DIGIT = 4, 1, 16; WIDTH = 16).
//   Directed scenarios run on the DIGIT=4 instance; the random regression
//   runs all three together against an integer-arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_multicycle_adder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start4;
  logic        start_x;
  logic [15:0] a;
  logic [15:0] b;
  logic        c_in;
  logic        sub;

  logic        busy4, done4, cout4, ovf4;
  logic [15:0] sum4;
  logic        busy1, done1, cout1, ovf1;
  logic [15:0] sum1;
  logic        busy16, done16, cout16, ovf16;
  logic [15:0] sum16;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  multicycle_adder #(.WIDTH(16), .DIGIT(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a), .b(b), .c_in(c_in),
    .sub(sub), .busy(busy4), .done(done4), .sum(sum4), .c_out(cout4), .ovf(ovf4)
  );

  multicycle_adder #(.WIDTH(16), .DIGIT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_x), .a(a), .b(b), .c_in(c_in),
    .sub(sub), .busy(busy1), .done(done1), .sum(sum1), .c_out(cout1), .ovf(ovf1)
  );

  multicycle_adder #(.WIDTH(16), .DIGIT(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start_x), .a(a), .b(b), .c_in(c_in),
    .sub(sub), .busy(busy16), .done(done16), .sum(sum16), .c_out(cout16), .ovf(ovf16)
  );

  // Reference: plain integer arithmetic. Returns {ovf, c_out, sum}.
  function automatic logic [17:0] ref_model(input logic [15:0] x, input logic [15:0] y,
                                            input logic ci, input logic s);
    int   ux, uy, sx, sy, ur, sr;
    logic co, ov;
    ux = int'(x);
    uy = int'(y);
    sx = int'($signed(x));
    sy = int'($signed(y));
    if (s) begin
      ur = ux - uy;
      co = (ux >= uy);
      sr = sx - sy;
    end else begin
      ur = ux + uy + int'(ci);
      co = (ur > 65535);
      sr = sx + sy + int'(ci);
    end
    ov = (sr > 32767) || (sr < -32768);
    return {ov, co, ur[15:0]};
  endfunction

  // Launches one op on dut4 from a point away from the rising edge, then
  // watches falling edges: returns the index of the done edge (-1 = timeout)
  // and the number of busy samples up to and including it.
  task automatic run_op4(input logic [15:0] xa, input logic [15:0] xb,
                         input logic ci, input logic s,
                         output int lat, output int busy_cnt);
    a = xa; b = xb; c_in = ci; sub = s; start4 = 1'b1;
    @(posedge clk);
    #1 start4 = 1'b0;
    lat = -1;
    busy_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy4) busy_cnt++;
      if (done4) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int lat, bc;
    rst_n = 1'b0; start4 = 1'b1; start_x = 1'b1;
    a = 16'h1234; b = 16'h4321; c_in = 1'b1; sub = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy4, done4, sum4, cout4, ovf4} !== 20'h0) begin
      errors++;
      $display("FAIL reset_dut4: got %h expected 0", {busy4, done4, sum4, cout4, ovf4});
    end
    checks++;
    if ({busy1, done1, sum1, cout1, ovf1, busy16, done16, sum16, cout16, ovf16} !== 40'h0) begin
      errors++;
      $display("FAIL reset_dut1_16: got %h expected 0",
               {busy1, done1, sum1, cout1, ovf1, busy16, done16, sum16, cout16, ovf16});
    end
    // First edge with rst_n high must accept the pending start.
    start_x = 1'b0;
    a = 16'h0003; b = 16'h0004; c_in = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1 start4 = 1'b0;
    @(negedge clk);
    checks++;
    if (busy4 !== 1'b1) begin
      errors++;
      $display("FAIL first_start_after_reset: busy got %b expected 1", busy4);
    end
    lat = -1;
    for (int i = 1; i < 40; i++) begin
      @(negedge clk);
      if (done4) begin lat = i; break; end
    end
    checks++;
    if (lat !== 4 || sum4 !== 16'h0007) begin
      errors++;
      $display("FAIL first_op_after_reset: lat %0d sum %h expected lat 4 sum 0007", lat, sum4);
    end
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [15:0] ta [5] = '{16'hFFFF, 16'h7FFF, 16'h0000, 16'h0005, 16'h8000};
    logic [15:0] tb [5] = '{16'h0001, 16'h0001, 16'h0000, 16'h0007, 16'h0001};
    logic        tc [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic        ts [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [17:0] te [5] = '{{1'b0, 1'b1, 16'h0000}, {1'b1, 1'b0, 16'h8000},
                            {1'b0, 1'b0, 16'h0001}, {1'b0, 1'b0, 16'hFFFE},
                            {1'b1, 1'b1, 16'h7FFF}};
    int lat, bc;
    for (int k = 0; k < 5; k++) begin
      run_op4(ta[k], tb[k], tc[k], ts[k], lat, bc);
      checks++;
      if (lat !== 4 || bc !== 5) begin
        errors++;
        $display("FAIL directed_timing[%0d]: lat %0d busy %0d expected lat 4 busy 5", k, lat, bc);
      end
      checks++;
      if ({ovf4, cout4, sum4} !== te[k]) begin
        errors++;
        $display("FAIL directed_result[%0d]: got %h expected %h", k, {ovf4, cout4, sum4}, te[k]);
      end
      @(negedge clk);
      checks++;
      if (busy4 !== 1'b0 || done4 !== 1'b0 || {ovf4, cout4, sum4} !== te[k]) begin
        errors++;
        $display("FAIL directed_hold[%0d]: busy %b done %b result %h expected 0 0 %h",
                 k, busy4, done4, {ovf4, cout4, sum4}, te[k]);
      end
    end
  endtask

  task automatic test_ignore_start();
    int lat;
    a = 16'h1234; b = 16'h1111; c_in = 1'b0; sub = 1'b0; start4 = 1'b1;
    @(posedge clk);
    #1;
    a = 16'hFFFF; b = 16'hFFFF; c_in = 1'b1; sub = 1'b1;
    lat = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done4) begin lat = i; break; end
    end
    checks++;
    if (lat !== 4 || {ovf4, cout4, sum4} !== {2'b00, 16'h2345}) begin
      errors++;
      $display("FAIL ignore_start_result: lat %0d result %h expected lat 4 result 02345",
               lat, {ovf4, cout4, sum4});
    end
    @(posedge clk);
    #1 start4 = 1'b0;
    @(negedge clk);
    checks++;
    if (busy4 !== 1'b0 || sum4 !== 16'h2345) begin
      errors++;
      $display("FAIL ignore_start_in_done: busy %b sum %h expected 0 2345", busy4, sum4);
    end
  endtask

  task automatic test_back_to_back();
    int dq[$];
    a = 16'h0100; b = 16'h0023; c_in = 1'b1; sub = 1'b0; start4 = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done4) begin
        dq.push_back(i);
        checks++;
        if (sum4 !== 16'h0124) begin
          errors++;
          $display("FAIL b2b_sum: got %h expected 0124", sum4);
        end
      end
    end
    start4 = 1'b0;
    checks++;
    if (dq.size() !== 3 || dq[0] !== 4 || dq[1] - dq[0] !== 6 || dq[2] - dq[1] !== 6) begin
      errors++;
      $display("FAIL b2b_spacing: got %0d dones first %0d expected 3 dones at 4,10,16",
               dq.size(), (dq.size() > 0) ? dq[0] : -1);
    end
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset_mid_run();
    int lat, bc, ndone;
    a = 16'h1111; b = 16'h2222; c_in = 1'b0; sub = 1'b0; start4 = 1'b1;
    @(posedge clk);
    #1 start4 = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy4, done4, sum4, cout4, ovf4} !== 20'h0) begin
      errors++;
      $display("FAIL mid_run_reset: got %h expected 0", {busy4, done4, sum4, cout4, ovf4});
    end
    ndone = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done4 || busy4) ndone++;
    end
    checks++;
    if (ndone !== 0) begin
      errors++;
      $display("FAIL mid_run_no_done: got %0d active cycles expected 0", ndone);
    end
    run_op4(16'h1111, 16'h2222, 1'b0, 1'b0, lat, bc);
    checks++;
    if (lat !== 4 || {ovf4, cout4, sum4} !== {2'b00, 16'h3333}) begin
      errors++;
      $display("FAIL after_reset_op: lat %0d result %h expected lat 4 result 03333",
               lat, {ovf4, cout4, sum4});
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [17:0] exp_v, r1, r4, r16;
    int l1, l4, l16;
    for (int n = 0; n < 40; n++) begin
      a = 16'($urandom); b = 16'($urandom);
      c_in = 1'($urandom); sub = 1'($urandom);
      if (n < 4) begin
        a = (n[0]) ? 16'h8000 : 16'hFFFF;
        b = (n[1]) ? 16'h7FFF : 16'h8000;
      end
      exp_v = ref_model(a, b, c_in, sub);
      start4 = 1'b1; start_x = 1'b1;
      @(posedge clk);
      #1 start4 = 1'b0; start_x = 1'b0;
      l1 = -1; l4 = -1; l16 = -1;
      r1 = '0; r4 = '0; r16 = '0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (done1 && l1 < 0) begin l1 = i; r1 = {ovf1, cout1, sum1}; end
        if (done4 && l4 < 0) begin l4 = i; r4 = {ovf4, cout4, sum4}; end
        if (done16 && l16 < 0) begin l16 = i; r16 = {ovf16, cout16, sum16}; end
        if (l1 >= 0 && l4 >= 0 && l16 >= 0) break;
      end
      checks++;
      if (l1 !== 16 || l4 !== 4 || l16 !== 1) begin
        errors++;
        $display("FAIL rand_latency[%0d]: got %0d/%0d/%0d expected 16/4/1", n, l1, l4, l16);
      end
      checks++;
      if (r1 !== exp_v || r4 !== exp_v || r16 !== exp_v) begin
        errors++;
        $display("FAIL rand_result[%0d]: a %h b %h ci %b sub %b got %h/%h/%h expected %h",
                 n, a, b, c_in, sub, r1, r4, r16, exp_v);
      end
      repeat (2) @(negedge clk);
    end
  endtask

  initial begin
    rst_n = 1'b0; start4 = 1'b0; start_x = 1'b0;
    a = 16'h0; b = 16'h0; c_in = 1'b0; sub = 1'b0;
    @(negedge clk);
    test_reset();
    test_directed();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid_run();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
